div: RTL and testbench
======================

# div

Iterative 32-bit integer divider for the execute stage, the counterpart to the Booth/Wallace multiplier: it serves DIV/DIVU and returns the quotient and remainder in the same {HI, LO} 64-bit format the multiplier uses. It is a radix-2 restoring divider with one quotient bit per cycle, using a start/ready handshake and a flush abort. It sits beside the multiplier in the EX stage and shares its request protocol.

## Interface
- No parameters. Operand width is fixed at 32 and result width at 64.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush. Synchronous abort, same effect as rst.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled at accept.
- opdata1_i  in  32  dividend. Sampled at accept.
- opdata2_i  in  32  divisor. Sampled at accept.
- start_i  in  1  request level. The requester holds it high until it sees ready_o.
- result_o  out  64  {remainder[31:0], quotient[31:0]}, i.e. {HI, LO}. Registered.
- ready_o  out  1  result-valid pulse, one cycle wide.

## Operation
- The FSM has three states: IDLE, CALC and DONE. On reset, state is IDLE, cnt is 0, and result_o and ready_o are both 0.
- **IDLE.** If start_i is high, the block accepts the request:
  - It latches |opdata1_i| and |opdata2_i| (absolute value only when signed_div_i=1 and the sign bit is set) into dividend and divisor registers.
  - It latches sign_q = s & (op1[31] ^ op2[31]), sign_r = s & op1[31], and div0 = (opdata2_i == 0).
  - It clears the partial remainder (33 bits), sets cnt = 0, and moves to CALC.
- **CALC.** Each cycle performs one restoring step:
  - Shift {rem, dividend} left by 1.
  - Compute trial = rem[32:0] − {1'b0, divisor}.
  - If trial is non-negative, rem = trial and the quotient bit is 1. Otherwise rem is kept and the quotient bit is 0. Quotient bits shift into the freed dividend LSB.
  - cnt increments. The step with cnt == 31 is the last one, and the state moves to DONE.
- **Entering DONE,** result_o is registered as follows:
  - Quotient: negated if sign_q. Remainder: negated if sign_r. Arithmetic is mod 2^32.
  - If div0 is set, quotient = 32'hFFFFFFFF and remainder = the original opdata1_i, in both signed and unsigned mode.
  - ready_o is set to 1.
- **DONE.** ready_o is 1 for this one cycle, and the next state is IDLE unconditionally. start_i is ignored in DONE.
- **Result hold.** result_o holds its value after DONE until the next accept or rst/flush. ready_o is 0 in every state except DONE.
- **Signed overflow.** 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0, from the natural wrap. No trap.
- **Operand changes.** Changes to opdata*_i or signed_div_i after accept do not affect the operation in flight.
- **rst or flush** in any cycle, including mid-CALC and in DONE:
  - The next state is IDLE, ready_o = 0, result_o = 0, cnt = 0.
  - A start_i that is high in the same cycle as flush is not accepted.
- **Deassert of start_i during CALC** does not abort the operation. Only flush aborts.

## Timing
- Latency is fixed at 34 cycles, including for div0:
  - start_i is high in IDLE in cycle T.
  - CALC occupies cycles T+1 through T+32.
  - ready_o and a valid result_o appear in cycle T+33.
- The requester sees ready_o in T+33 and drops start_i, or presents a new request, from T+34.
- If start_i is still high in T+34, the block is back in IDLE and accepts a new operation. Back-to-back throughput is one operation every 34 cycles.
- There is no combinational path from any input to result_o or ready_o.

## Test plan
- **Unsigned divide.** Unsigned, 100 / 7, start_i at T → ready_o=1 only in T+33, result_o = 64'h00000002_0000000E. ready_o=0 at T+32 and at T+34.
- **Signed sign rules.**
  - Signed −7 / 2 (0xFFFFFFF9 / 0x2) → result_o = 64'hFFFFFFFF_FFFFFFFD.
  - Signed 7 / −2 → 64'h00000001_FFFFFFFD.
- **Overflow case.**
  - Signed 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
  - The same operands unsigned → 64'h80000000_00000000.
- **Divide by zero.** Unsigned 5 / 0 → 64'h00000005_FFFFFFFF at T+33. Signed 0xFFFFFFF0 / 0 → 64'hFFFFFFF0_FFFFFFFF.
- **Flush mid-operation.** Start 100/7 at T, pulse flush at T+10 → no ready_o pulse at T+33, result_o = 0 from T+11. Start 9/3 at T+40 → 64'h00000000_00000003 at T+73.
- **Back-to-back and operand isolation.**
  - Hold start_i high through T+34 with new operands 0xFFFFFFFF / 0x10 unsigned, presented from T+34 → second ready_o at T+67, result 64'h0000000F_0FFFFFFF.
  - Operands toggled randomly during CALC do not change the result.

Source files
------------

// File: rtl/div.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU: one quotient bit per cycle, fixed 34-cycle latency.
// Returns {remainder, quotient} in the same {HI, LO} layout as the multiplier.
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t      state;
   state_t      next_state;
   logic        accept;
   logic        last;

   logic [4:0]  cnt;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] op1_orig;
   logic [32:0] rem;
   logic        sign_q;
   logic        sign_r;
   logic        div0;

   logic [31:0] abs1;
   logic [31:0] abs2;
   logic [33:0] shifted;
   logic [32:0] trial;
   logic        qbit;
   logic [32:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] q_final;
   logic [31:0] r_final;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush)
         state <= IDLE;
      else
         state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               accept     = 1'b1;
               next_state = CALC;
            end
         end
         CALC: begin
            if (cnt == 5'd31) begin
               last       = 1'b1;
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Magnitudes of the operands; DIVU passes them through untouched.
   always_comb begin
      abs1 = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
      abs2 = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
   end

   // One restoring step: shift {rem, dividend} left, subtract divisor if it fits.
   always_comb begin
      shifted  = {rem, dividend[31]};
      qbit     = (shifted >= {2'b00, divisor});
      trial    = shifted[32:0] - {1'b0, divisor};
      rem_next = qbit ? trial : shifted[32:0];
      quo_next = {dividend[30:0], qbit};
   end

   // Final sign fix-up and divide-by-zero override, applied on the last step.
   always_comb begin
      q_final = sign_q ? (32'd0 - quo_next) : quo_next;
      r_final = sign_r ? (32'd0 - rem_next[31:0]) : rem_next[31:0];
      if (div0) begin
         q_final = 32'hFFFF_FFFF;
         r_final = op1_orig;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cnt      <= 5'd0;
         dividend <= 32'd0;
         divisor  <= 32'd0;
         op1_orig <= 32'd0;
         rem      <= 33'd0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         div0     <= 1'b0;
         result_o <= 64'd0;
         ready_o  <= 1'b0;
      end else begin
         ready_o <= last;
         if (accept) begin
            dividend <= abs1;
            divisor  <= abs2;
            op1_orig <= opdata1_i;
            sign_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            sign_r   <= signed_div_i & opdata1_i[31];
            div0     <= (opdata2_i == 32'd0);
            rem      <= 33'd0;
            cnt      <= 5'd0;
         end else if (state == CALC) begin
            rem      <= rem_next;
            dividend <= quo_next;
            cnt      <= cnt + 5'd1;
            if (last)
               result_o <= {r_final, q_final};
         end
      end
   end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized operations
// checked against an arithmetic reference model, with operand scrambling during CALC.
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_cmp = 0;
   int n_err = 0;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero, remainder takes dividend sign.
   function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [31:0] uq;
      logic [31:0] ur;
      if (b == 32'd0)
         return {a, 32'hFFFF_FFFF};
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
   endtask

   // Called in the accept cycle T; returns in the cycle ready_o is seen (expected T+33).
   task automatic await_ready(input string tag);
      int lat;
      lat = 0;
      while (ready_o !== 1'b1 && lat < 40) begin
         step();
         lat++;
         if (lat < 33) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
         end
      end
      check({tag, " latency"}, 64'(lat), 64'd33);
   endtask

   task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      launch(s, a, b);
      await_ready(tag);
      check({tag, " result"}, result_o, exp);
      start_i = 1'b0;
      step();
      check({tag, " ready after"}, 64'(ready_o), 64'd0);
      check({tag, " result hold"}, result_o, exp);
   endtask

   task automatic quiet_window(input string tag, input int n);
      bit seen;
      seen = 1'b0;
      repeat (n) begin
         step();
         if (ready_o !== 1'b0 || result_o !== 64'd0)
            seen = 1'b1;
      end
      check({tag, " no ready"}, 64'(seen), 64'd0);
   endtask

   initial begin
      rst          = 1'b1;
      flush        = 1'b0;
      start_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = 32'd0;
      opdata2_i    = 32'd0;
      repeat (3) step();
      check("reset ready", 64'(ready_o), 64'd0);
      check("reset result", result_o, 64'd0);
      rst = 1'b0;
      step();
      check("idle ready", 64'(ready_o), 64'd0);

      run_op("u 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
      run_op("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
      run_op("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD);
      run_op("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
      run_op("u ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000);
      run_op("u 5/0", 1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
      run_op("s -16/0", 1'b1, 32'hFFFF_FFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF);

      // Flush mid-CALC at T+10, start held high through the flush cycle.
      launch(1'b0, 32'd100, 32'd7);
      repeat (10) step();
      flush = 1'b1;
      step();
      flush   = 1'b0;
      start_i = 1'b0;
      check("flush result", result_o, 64'd0);
      check("flush ready", 64'(ready_o), 64'd0);
      quiet_window("flush", 29);
      run_op("after flush 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

      // start_i alongside flush in IDLE must not be accepted.
      launch(1'b0, 32'd50, 32'd5);
      flush = 1'b1;
      step();
      flush   = 1'b0;
      start_i = 1'b0;
      quiet_window("idle flush+start", 40);

      // rst mid-CALC behaves like flush.
      launch(1'b1, 32'd1234, 32'd5);
      repeat (5) step();
      rst = 1'b1;
      step();
      rst     = 1'b0;
      start_i = 1'b0;
      check("rst mid result", result_o, 64'd0);
      quiet_window("rst mid", 40);

      // Back-to-back: start held high through T+34, new operands from T+34.
      launch(1'b0, 32'd1000, 32'd3);
      await_ready("b2b first");
      check("b2b first result", result_o, 64'h00000001_0000014D);
      step();
      check("b2b gap ready", 64'(ready_o), 64'd0);
      launch(1'b0, 32'hFFFF_FFFF, 32'h10);
      await_ready("b2b second");
      check("b2b second result", result_o, 64'h0000000F_0FFFFFFF);
      start_i = 1'b0;
      step();
      check("b2b end ready", 64'(ready_o), 64'd0);

      for (int i = 0; i < 50; i++) begin
         bit          s;
         logic [31:0] a;
         logic [31:0] b;
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         if ($urandom_range(0, 7) == 0)
            a = 32'h8000_0000;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            3:       b = a;
            default: b = $urandom;
         endcase
         run_op("random", s, a, b, model(s, a, b));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
